// File: rtl/keccak_absorb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : keccak_absorb
// Brief    : SHAKE sponge absorb stage. XORs 64-bit message lanes into the
//            rate part of the 1600-bit Keccak state, applies pad10*1 with
//            domain separation and hands each full block to an external
//            Keccak-f permutation through a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_absorb #(
    parameter int          RATE_LANES = 21,
    parameter logic [7:0]  DOMAIN     = 8'h1F
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [63:0]                 in_data,
    input  logic                        in_last,
    input  logic [3:0]                  in_bytes,
    output logic                        perm_start,
    input  logic                        perm_done,
    input  logic [4:0][4:0][63:0]       state_in,
    output logic [4:0][4:0][63:0]       state_out,
    output logic                        absorb_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABSORB = 3'd1,
        S_PAD    = 3'd2,
        S_PERM   = 3'd3,
        S_DONE   = 3'd4
    } fsm_t;

    localparam logic [4:0]  c_last_idx = 5'(RATE_LANES - 1);
    localparam logic [63:0] c_pad_end  = 64'h8000_0000_0000_0000;

    fsm_t                  r_fsm;
    fsm_t                  w_fsm_nxt;
    logic [4:0]            r_lane_idx;
    logic [4:0]            w_lane_nxt;
    logic                  r_final_perm;
    logic                  w_final_nxt;
    logic                  r_pad_pending;
    logic                  w_padp_nxt;
    logic                  r_perm_start;
    logic                  w_perm_start_nxt;
    logic [4:0][4:0][63:0] r_state;
    logic [4:0][4:0][63:0] w_state_nxt;

    // Datapath control decoded by the FSM
    logic                  w_clear;
    logic                  w_capture;
    logic                  w_xor_en;
    logic                  w_xor_end;
    logic [63:0]           w_xor_lane;

    // Last-lane formatting: byte counts above 8 behave as a full lane
    logic [3:0]            w_nbytes;
    logic                  w_short;
    logic [5:0]            w_shamt;
    logic [63:0]           w_mask;
    logic [63:0]           w_last_lane;

    assign w_nbytes    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign w_short     = ~w_nbytes[3];
    assign w_shamt     = {w_nbytes[2:0], 3'b000};
    assign w_mask      = w_short ? ((64'd1 << w_shamt) - 64'd1) : {64{1'b1}};
    assign w_last_lane = (in_data & w_mask)
                       | (w_short ? ({56'd0, DOMAIN} << w_shamt) : 64'd0);

    assign in_ready    = (r_fsm == S_ABSORB);
    assign absorb_done = (r_fsm == S_DONE);
    assign perm_start  = r_perm_start;
    assign state_out   = r_state;

    // Next-state and datapath-control decode
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_lane_nxt  = r_lane_idx;
        w_final_nxt = r_final_perm;
        w_padp_nxt  = r_pad_pending;
        w_clear     = 1'b0;
        w_capture   = 1'b0;
        w_xor_en    = 1'b0;
        w_xor_end   = 1'b0;
        w_xor_lane  = 64'd0;
        case (r_fsm)
            S_IDLE, S_DONE: begin
                if (init) begin
                    w_clear     = 1'b1;
                    w_lane_nxt  = 5'd0;
                    w_final_nxt = 1'b0;
                    w_padp_nxt  = 1'b0;
                    w_fsm_nxt   = S_ABSORB;
                end
            end
            S_ABSORB: begin
                if (in_valid) begin
                    w_xor_en   = 1'b1;
                    w_xor_lane = in_last ? w_last_lane : in_data;
                    if (in_last && w_short) begin
                        // Short last lane carries the domain byte itself
                        w_xor_end   = 1'b1;
                        w_final_nxt = 1'b1;
                        w_fsm_nxt   = S_PERM;
                    end else if (r_lane_idx == c_last_idx) begin
                        // Block full; a full last lane defers padding to a fresh block
                        w_lane_nxt = 5'd0;
                        w_padp_nxt = in_last;
                        w_fsm_nxt  = S_PERM;
                    end else begin
                        w_lane_nxt = r_lane_idx + 5'd1;
                        w_fsm_nxt  = in_last ? S_PAD : S_ABSORB;
                    end
                end
            end
            S_PAD: begin
                w_xor_en    = 1'b1;
                w_xor_lane  = {56'd0, DOMAIN};
                w_xor_end   = 1'b1;
                w_final_nxt = 1'b1;
                w_fsm_nxt   = S_PERM;
            end
            S_PERM: begin
                // The cycle carrying perm_start cannot also complete the permutation
                if (perm_done && !r_perm_start) begin
                    w_capture = 1'b1;
                    if (r_final_perm) begin
                        w_fsm_nxt = S_DONE;
                    end else if (r_pad_pending) begin
                        w_padp_nxt = 1'b0;
                        w_fsm_nxt  = S_PAD;
                    end else begin
                        w_fsm_nxt = S_ABSORB;
                    end
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
        w_perm_start_nxt = (w_fsm_nxt == S_PERM) && (r_fsm != S_PERM);
    end

    // Next Keccak state: clear, capture permutation result, or lane XORs
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear) begin
            w_state_nxt = '0;
        end else if (w_capture) begin
            w_state_nxt = state_in;
        end else begin
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < 5; x++) begin
                    if (w_xor_en && ((y * 5 + x) == int'(r_lane_idx)))
                        w_state_nxt[x][y] = w_state_nxt[x][y] ^ w_xor_lane;
                    if (w_xor_end && ((y * 5 + x) == (RATE_LANES - 1)))
                        w_state_nxt[x][y] = w_state_nxt[x][y] ^ c_pad_end;
                end
            end
        end
    end

    // State, FSM and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm         <= S_IDLE;
            r_lane_idx    <= 5'd0;
            r_final_perm  <= 1'b0;
            r_pad_pending <= 1'b0;
            r_perm_start  <= 1'b0;
            r_state       <= '0;
        end else begin
            r_fsm         <= w_fsm_nxt;
            r_lane_idx    <= w_lane_nxt;
            r_final_perm  <= w_final_nxt;
            r_pad_pending <= w_padp_nxt;
            r_perm_start  <= w_perm_start_nxt;
            r_state       <= w_state_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_absorb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_keccak_absorb
// Brief    : Scoreboard bench for keccak_absorb (SHAKE128 and SHAKE256 rates)
//            with a fixed-latency permutation stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keccak_absorb;

    typedef logic [4:0][4:0][63:0] st_t;
    typedef struct {
        bit  is_done;
        st_t st;
    } exp_t;

    localparam logic [63:0] c_end = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_tw  = 64'hA5A5_0000_0000_5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic        in_valid;
    logic        in_last;
    logic        perm_done;
    logic        sel;
    logic [63:0] in_data;
    logic [3:0]  in_bytes;
    st_t         state_in;
    logic [63:0] tweak;

    logic rdy21, ps21, ad21, rdy17, ps17, ad17;
    st_t  so21, so17;
    logic in_ready_m, perm_start_m, absorb_done_m;
    st_t  state_out_m;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_pstart = 0;
    int   pstart_cyc = 0;
    int   viol = 0;
    bit   prev_done = 1'b0;
    bit   busy = 1'b0;
    exp_t exp_q[$];
    st_t  stub_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keccak_absorb #(.RATE_LANES(21), .DOMAIN(8'h1F)) u21 (
        .clk(clk), .rst(rst), .init(init & ~sel), .in_valid(in_valid & ~sel),
        .in_ready(rdy21), .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
        .perm_start(ps21), .perm_done(perm_done & ~sel), .state_in(state_in),
        .state_out(so21), .absorb_done(ad21));

    keccak_absorb #(.RATE_LANES(17), .DOMAIN(8'h1F)) u17 (
        .clk(clk), .rst(rst), .init(init & sel), .in_valid(in_valid & sel),
        .in_ready(rdy17), .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
        .perm_start(ps17), .perm_done(perm_done & sel), .state_in(state_in),
        .state_out(so17), .absorb_done(ad17));

    assign in_ready_m    = sel ? rdy17 : rdy21;
    assign perm_start_m  = sel ? ps17  : ps21;
    assign absorb_done_m = sel ? ad17  : ad21;
    assign state_out_m   = sel ? so17  : so21;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input st_t act, input st_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int i = 0; i < 25; i++) begin
                if (act[i%5][i/5] !== exp[i%5][i/5]) begin
                    $display("FAIL %s: lane %0d got %h expected %h", name, i,
                             act[i%5][i/5], exp[i%5][i/5]);
                    break;
                end
            end
        end
    endtask

    function automatic st_t setl(input st_t s, input int i, input logic [63:0] v);
        st_t r;
        r = s;
        r[i%5][i/5] = v;
        return r;
    endfunction

    task automatic push(input bit is_done, input st_t st);
        exp_t e;
        e.is_done = is_done;
        e.st      = st;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input bit is_done, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: unexpected event, got event expected none", name);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done != is_done) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: got event kind %0d expected kind %0d", name, is_done, e.is_done);
            end else begin
                chk_state(name, state_out_m, e.st);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic send_lane(input logic [63:0] d, input bit last, input logic [3:0] nb);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready_m && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!absorb_done_m && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got absorb_done 0 expected 1");
        end
        repeat (2) tick();
    endtask

    // Permutation stub: returns state_out (capacity lane 24 XOR tweak) 3 cycles after perm_start
    initial begin
        perm_done = 1'b0;
        state_in  = '0;
        forever begin
            if (perm_start_m === 1'b1) begin
                stub_s = state_out_m;
                stub_s[4][4] = stub_s[4][4] ^ tweak;
                repeat (3) @(posedge clk);
                #1;
                state_in  = stub_s;
                perm_done = 1'b1;
                @(posedge clk);
                #1;
                perm_done = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    end

    // Monitor: compares state at every perm_start and at absorb_done rise
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_done = 1'b0;
                busy      = 1'b0;
            end else begin
                if (busy && in_ready_m) viol++;
                if (perm_done) busy = 1'b0;
                if (perm_start_m) begin
                    n_pstart++;
                    pstart_cyc = cyc;
                    busy = 1'b1;
                    pop_check(1'b0, "perm_start_state");
                end
                if (absorb_done_m && !prev_done) begin
                    chk("done_latency", 64'(cyc - pstart_cyc), 64'd4);
                    pop_check(1'b1, "done_state");
                end
                prev_done = absorb_done_m;
            end
        end
    end

    // Directed stimulus
    initial begin
        st_t e;
        int  base;
        int  vbase;
        rst = 1'b1; init = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_bytes = 4'd0; in_data = 64'd0; sel = 1'b0; tweak = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("reset_in_ready", 64'(in_ready_m), 64'd0);
        chk("reset_perm_start", 64'(perm_start_m), 64'd0);
        chk("reset_absorb_done", 64'(absorb_done_m), 64'd0);
        chk_state("reset_state", state_out_m, '0);

        // Empty message, identity permutation
        e = '0;
        e = setl(e, 0, 64'h1F);
        e = setl(e, 20, c_end);
        push(1'b0, e);
        push(1'b1, e);
        do_init();
        chk("init_in_ready", 64'(in_ready_m), 64'd1);
        send_lane(64'd0, 1'b1, 4'd0);
        wait_done();
        chk("done_in_ready", 64'(in_ready_m), 64'd0);

        // 3-byte message with garbage above the valid bytes
        tweak = c_tw;
        e = '0;
        e = setl(e, 0, 64'h1FAB_CDEF);
        e = setl(e, 20, c_end);
        push(1'b0, e);
        e[4][4] = e[4][4] ^ c_tw;
        push(1'b1, e);
        do_init();
        send_lane(64'hDEAD_BEEF_00AB_CDEF, 1'b1, 4'd3);
        wait_done();

        // 21 full lanes: padding goes in an extra block
        base = n_pstart;
        e = '0;
        for (int i = 0; i < 21; i++) e = setl(e, i, 64'h1);
        push(1'b0, e);
        e[4][4] = e[4][4] ^ c_tw;
        e = setl(e, 0, 64'h1E);
        e = setl(e, 20, 64'h8000_0000_0000_0001);
        push(1'b0, e);
        e[4][4] = e[4][4] ^ c_tw;
        push(1'b1, e);
        do_init();
        send_lane(64'h1, 1'b0, 4'd0);
        chk("lane_xor_visible", state_out_m[0][0], 64'h1);
        for (int i = 1; i < 20; i++) send_lane(64'h1, 1'b0, 4'd0);
        send_lane(64'h1, 1'b1, 4'd8);
        wait_done();
        chk("extra_block_pstarts", 64'(n_pstart - base), 64'd2);

        // 20 full lanes, last full lane (byte count 12 acts as 8): PAD fills lane 20
        base = n_pstart;
        e = '0;
        for (int i = 0; i < 20; i++) e = setl(e, i, 64'h1);
        e = setl(e, 20, 64'h8000_0000_0000_001F);
        push(1'b0, e);
        e[4][4] = e[4][4] ^ c_tw;
        push(1'b1, e);
        do_init();
        for (int i = 0; i < 19; i++) send_lane(64'h1, 1'b0, 4'd0);
        send_lane(64'h1, 1'b1, 4'd12);
        wait_done();
        chk("pad_lane20_pstarts", 64'(n_pstart - base), 64'd1);

        // Reset while permuting; the late perm_done must be ignored
        e = '0;
        e = setl(e, 0, 64'h1F_1234);
        e = setl(e, 20, c_end);
        push(1'b0, e);
        do_init();
        send_lane(64'h1234, 1'b1, 4'd2);
        tick();
        base = n_pstart;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_perm_start", 64'(perm_start_m), 64'd0);
        chk_state("rst_async_state", state_out_m, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) tick();
        chk("rst_in_ready", 64'(in_ready_m), 64'd0);
        chk("rst_absorb_done", 64'(absorb_done_m), 64'd0);
        chk_state("rst_state_after_done", state_out_m, '0);
        chk("rst_no_pstart", 64'(n_pstart - base), 64'd0);

        // SHAKE256 rate: two full blocks then a 5-byte last lane
        sel = 1'b1;
        tick();
        base  = n_pstart;
        vbase = viol;
        e = '0;
        for (int i = 0; i < 17; i++) e = setl(e, i, 64'h1);
        push(1'b0, e);
        e[4][4] = e[4][4] ^ c_tw;
        for (int i = 0; i < 17; i++) e = setl(e, i, 64'h3);
        push(1'b0, e);
        e[4][4] = e[4][4] ^ c_tw;
        e = setl(e, 0, 64'h0000_1FFF_FFFF_FFFC);
        e = setl(e, 16, 64'h8000_0000_0000_0003);
        push(1'b0, e);
        e[4][4] = e[4][4] ^ c_tw;
        push(1'b1, e);
        do_init();
        for (int i = 0; i < 17; i++) send_lane(64'h1, 1'b0, 4'd0);
        for (int i = 0; i < 17; i++) send_lane(64'h2, 1'b0, 4'd0);
        send_lane(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd5);
        wait_done();
        chk("r17_pstarts", 64'(n_pstart - base), 64'd3);
        chk("r17_ready_in_perm", 64'(viol - vbase), 64'd0);
        chk("r17_lane16", state_out_m[1][3], 64'h8000_0000_0000_0003);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keccak_absorb.md
# keccak_absorb

Sponge absorb stage for the SHAKE datapath. It accepts the message as a stream of 64-bit little-endian lanes and XORs each lane into the rate portion of the 1600-bit Keccak state. It applies SHAKE pad10*1 with domain separation, then sequences the Keccak-f permutation (theta first) through a start/done handshake once per rate block. When the final block has been permuted it holds the state for the squeeze logic.

## Interface
- RATE_LANES, 21, lanes per rate block (21 = SHAKE128, 17 = SHAKE256)
- DOMAIN, 8'h1F, domain/pad-start byte
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- init  in  1  start new message; clears state
- in_valid  in  1  input lane valid
- in_ready  out  1  block accepts lane
- in_data  in  64  message lane, byte 0 = bits [7:0]
- in_last  in  1  final lane of message
- in_bytes  in  4  valid bytes in last lane, 0..8 (9..15 treated as 8); ignored when in_last=0
- perm_start  out  1  one-cycle pulse: permute state_out
- perm_done  in  1  permutation result valid on state_in
- state_in  in  64 x [4:0][4:0]  permuted state, A[x][y]
- state_out  out  64 x [4:0][4:0]  registered current state, A[x][y]
- absorb_done  out  1  level: absorption complete, state_out final

## Operation
- Lane index i maps to A[i%5][i/5]. lane_idx counts 0..RATE_LANES-1.
- FSM states: IDLE, ABSORB, PAD, PERM, DONE. Flags: final_perm, pad_pending.
- IDLE/DONE + init: clear state to 0, lane_idx=0, flags=0, go ABSORB. init is ignored in ABSORB, PAD and PERM.
- ABSORB: in_ready=1. Handshake is in_valid & in_ready.
  - Non-last handshake: lane ^= in_data, lane_idx++. If lane_idx was RATE_LANES-1: lane_idx=0, go PERM.
  - Last with n=in_bytes<8: lane ^= (in_data masked to n bytes) | (DOMAIN << 8n). Lane RATE_LANES-1 ^= 0x80<<56; both XORs apply if it is the same lane. Set final_perm, go PERM.
  - Last with n=8 and lane_idx<RATE_LANES-1: lane ^= in_data, lane_idx++, go PAD.
  - Last with n=8 and lane_idx=RATE_LANES-1: lane ^= in_data, lane_idx=0, set pad_pending, go PERM.
- PAD (one cycle): lane[lane_idx] ^= DOMAIN. Lane RATE_LANES-1 ^= 0x80<<56. Set final_perm, go PERM.
- PERM: wait for perm_done. On perm_done, state <= state_in, then:
  - final_perm set: go DONE.
  - pad_pending set: clear it, go PAD.
  - otherwise: go ABSORB.
- DONE: absorb_done=1, in_ready=0, state frozen.
- perm_done outside PERM is ignored.

## Timing
- Reset values:
  - state all 0, lane_idx 0, FSM IDLE, flags 0.
  - in_ready 0, perm_start 0, absorb_done 0.
- rst mid-operation (any state) returns to IDLE immediately. A perm_done arriving afterwards is ignored.
- in_ready = (FSM==ABSORB), registered. One lane per cycle at full throughput.
- Lane XOR is visible on state_out the cycle after the handshake.
- perm_start is high exactly the first cycle in PERM, i.e. cycle t+1 for a handshake or PAD cycle at t. state_out is stable for the whole of PERM.
- perm_done is honoured from the cycle after perm_start onward. Result captured on that edge.
  - Next lane can be accepted the cycle after perm_done.
  - absorb_done rises the cycle after the final perm_done.
- Full block cost: RATE_LANES cycles + permutation latency + 1.

## Test plan
- Empty message, RATE_LANES=21, permutation stub returns state unchanged after 3 cycles. Stimulus: init, then in_last=1, in_bytes=0.
  - At perm_start: A[0][0]=64'h1F, A[0][4]=64'h8000_0000_0000_0000, all other lanes 0.
  - absorb_done rises 4 cycles after perm_start.
- 3-byte message 0xABCDEF: in_data=64'hAB_CDEF, in_last, in_bytes=3.
  - A[0][0]=64'h1FAB_CDEF, A[0][4]=0x80<<56.
- Exactly 21 full lanes of 64'h1, last lane with in_bytes=8 (PAD after extra block):
  - First perm_start with pad_pending set.
  - PAD puts 0x1F in A[0][0]; A[0][4] receives 0x80<<56.
  - Exactly 2 perm_start pulses total.
- 20 full lanes, last lane in_bytes=8 at lane_idx 19:
  - PAD cycle puts DOMAIN in lane 20 byte 0, giving A[0][4]=64'h8000_0000_0000_001F.
  - One perm_start only.
- rst asserted during PERM, then perm_done pulsed:
  - Outputs return to reset values, FSM stays IDLE, state stays 0.
- RATE_LANES=17, two full blocks then a short last lane (in_bytes=5):
  - 3 perm_start pulses.
  - in_ready low throughout each PERM.
  - 0x80<<56 lands in lane 16, i.e. A[1][3].
